tristatebus_monitor: RTL

Clocked, parametrised successor to the combinational tristate net model. It resolves INPUT_COUNT active-low-enabled drivers onto one WIDTH-bit bus and registers the result. It provides optional bus-keeper behaviour, filters switching overlap, and records contention in sticky, clearable registers. It sits on each shared data bus of the CPU model (data bus, address bus, ALU bus) so that the bench and the debug front panel can read bus ownership and contention history.

---
 rtl/tristatebus_pkg.sv | 17 +
 rtl/tristatebus_decode.sv | 37 +++
 rtl/tristatebus_monitor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tristatebus_pkg.sv
// Shared types and helpers for the tristate bus monitor.
package tristatebus_pkg;

    // Bus ownership state as seen by the monitor.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRIVEN     = 2'd1,
        SUSPECT    = 2'd2,
        CONTENTION = 2'd3
    } state_e;

    // Width of a driver index; never narrower than one bit.
    function automatic int unsigned owner_width(input int unsigned count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/tristatebus_decode.sv
// Combinational driver decode: which drivers are enabled, how many
// (saturating at 2), the index of the enabled driver, and the wired-AND
// of all enabled drivers' data. A bit of i_noe that is X/Z is not counted as an enable.
module tristatebus_decode
    import tristatebus_pkg::*;
#(
    parameter int unsigned INPUT_COUNT = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned OW          = owner_width(INPUT_COUNT)
) (
    input  logic [WIDTH*INPUT_COUNT-1:0] i_data,
    input  logic [INPUT_COUNT-1:0]       i_noe,
    output logic [INPUT_COUNT-1:0]       o_en,
    output logic [1:0]                   o_count,
    output logic [OW-1:0]                o_owner,
    output logic [WIDTH-1:0]             o_and_data
);

    // Scan all drivers; with exactly one enabled, o_and_data is its data.
    always_comb begin
        o_en       = '0;
        o_count    = '0;
        o_owner    = '0;
        o_and_data = '1;
        for (int unsigned k = 0; k < INPUT_COUNT; k++) begin
            if (i_noe[k] === 1'b0) begin
                o_en[k]    = 1'b1;
                o_owner    = OW'(k);
                o_and_data = o_and_data & i_data[WIDTH*k +: WIDTH];
                if (o_count != 2'd2) begin
                    o_count = o_count + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/tristatebus_monitor.sv
// Registered tristate bus resolver with optional bus keeper, overlap
// filter and sticky, clearable contention recording.
module tristatebus_monitor
    import tristatebus_pkg::*;
#(
    parameter int unsigned INPUT_COUNT   = 4,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned HOLD_MODE     = 0,
    parameter int unsigned FILTER_CYCLES = 1,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                                       i_clk,
    input  logic                                       i_nrst,
    input  logic [WIDTH*INPUT_COUNT-1:0]               i_data,
    input  logic [INPUT_COUNT-1:0]                     i_noe,
    input  logic                                       i_clr_err,
    output logic [WIDTH-1:0]                           o_data,
    output logic                                       o_noe,
    output logic [owner_width(INPUT_COUNT)-1:0]        o_owner,
    output logic                                       o_err,
    output logic [INPUT_COUNT-1:0]                     o_err_mask,
    output logic [CNT_WIDTH-1:0]                       o_err_cnt
);

    localparam int unsigned OW = owner_width(INPUT_COUNT);
    localparam int unsigned FW = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);

    logic [INPUT_COUNT-1:0] en;
    logic [1:0]             count;
    logic [OW-1:0]          owner;
    logic [WIDTH-1:0]       and_data;

    state_e                 state_q,  state_d;
    logic [FW-1:0]          filt_q,   filt_d;
    logic [WIDTH-1:0]       data_q,   data_d;
    logic [WIDTH-1:0]       hold_q,   hold_d;
    logic                   noe_q,    noe_d;
    logic [OW-1:0]          owner_q,  owner_d;
    logic                   err_q,    err_d;
    logic [INPUT_COUNT-1:0] mask_q,   mask_d;
    logic [CNT_WIDTH-1:0]   cnt_q,    cnt_d;
    logic                   evt;

    tristatebus_decode #(
        .INPUT_COUNT (INPUT_COUNT),
        .WIDTH       (WIDTH),
        .OW          (OW)
    ) u_decode (
        .i_data     (i_data),
        .i_noe      (i_noe),
        .o_en       (en),
        .o_count    (count),
        .o_owner    (owner),
        .o_and_data (and_data)
    );

    // Next state, overlap filter and bus value; evt marks entry into CONTENTION.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        data_d  = data_q;
        hold_d  = hold_q;
        noe_d   = 1'b1;
        owner_d = owner_q;
        evt     = 1'b0;
        unique case (count)
            2'd0: begin
                state_d = IDLE;
                filt_d  = '0;
                data_d  = (HOLD_MODE != 0) ? hold_q : '1;
            end
            2'd1: begin
                state_d = DRIVEN;
                filt_d  = '0;
                data_d  = and_data;
                hold_d  = and_data;
                noe_d   = 1'b0;
                owner_d = owner;
            end
            default: begin
                // The filter tolerates FILTER_CYCLES overlapping samples; the
                // next consecutive one is the contention event.
                if (state_q == CONTENTION) begin
                    data_d = and_data;
                end else if (state_q == SUSPECT && filt_q < FW'(FILTER_CYCLES)) begin
                    filt_d = filt_q + 1'b1;
                end else if (state_q != SUSPECT && FILTER_CYCLES != 0) begin
                    state_d = SUSPECT;
                    filt_d  = FW'(1);
                end else begin
                    state_d = CONTENTION;
                    data_d  = and_data;
                    evt     = 1'b1;
                end
            end
        endcase
    end

    // Sticky error bookkeeping; an event in the same cycle as a clear wins.
    always_comb begin
        err_d  = err_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        if (i_clr_err) begin
            err_d  = 1'b0;
            mask_d = '0;
            cnt_d  = '0;
        end
        if (evt) begin
            err_d = 1'b1;
            if (!err_q || i_clr_err) begin
                mask_d = en;
            end
            if (cnt_d != '1) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    // Bus state machine and registered bus outputs.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            filt_q  <= '0;
            data_q  <= '1;
            hold_q  <= '1;
            noe_q   <= 1'b1;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            noe_q   <= noe_d;
            owner_q <= owner_d;
        end
    end

    // Contention history registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            err_q  <= 1'b0;
            mask_q <= '0;
            cnt_q  <= '0;
        end else begin
            err_q  <= err_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_data     = data_q;
    assign o_noe      = noe_q;
    assign o_owner    = owner_q;
    assign o_err      = err_q;
    assign o_err_mask = mask_q;
    assign o_err_cnt  = cnt_q;

endmodule
